vtx1_bus_target_mem: RTL and testbench
======================================

Name: vtx1_bus_target_mem

Overview:
Word-addressed memory-mapped bus target (responder) for the VTX1 bus matrix. It answers the master-side request protocol that DMA and CPU masters drive (req/wr/size/addr/wdata in; rdata/ready/error/error_code/timeout out; error_clear in). It is backed by a local word array, inserts programmable wait states, and detects range, size, write-protect and stall-timeout faults with sticky error reporting. It is used as an on-chip scratch memory and as the bench target for bus-master verification.

Parameters:
ADDR_WIDTH, `VTX1_ADDR_WIDTH, address width
WORD_WIDTH, `VTX1_WORD_WIDTH, data word width
BASE_ADDR, 0x1000, first decoded word address
DEPTH, 256, number of words; power of 2, >= 2
WAIT_STATES, 2, extra cycles inserted before ready (0..15)
TIMEOUT_CYCLES, 16, stall cycles allowed in ACCESS before timeout (>= 1)
WP_BASE, 0x10F0, first write-protected address (inclusive)
WP_LIMIT, 0x10FF, last write-protected address (inclusive); WP_LIMIT < WP_BASE disables protection

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
bus_req  in  1  master request; held stable with addr/wr/size/wdata until ready
bus_wr  in  1  1 = write, 0 = read
bus_size  in  2  access size; only 2'b10 (word) is supported
bus_addr  in  ADDR_WIDTH  word address
bus_wdata  in  WORD_WIDTH  write data
bus_rdata  out  WORD_WIDTH  read data, valid while bus_ready=1 and bus_wr=0
bus_ready  out  1  one-cycle completion pulse
bus_error  out  1  sticky error flag
bus_error_code  out  4  sticky error code
bus_timeout  out  1  sticky timeout flag
bus_error_clear  in  1  clears the sticky error state
stall_in  in  1  backend stall; freezes the wait counter
rd_count  out  16  completed good reads, saturating
wr_count  out  16  completed good writes, saturating
err_count  out  16  faulted transactions, saturating

Behaviour:
- Reset: all outputs 0; state IDLE. Memory contents are not cleared.
- States: IDLE, ACCESS, RESPOND, ERR_HOLD. All outputs are registered.
- IDLE: on bus_req=1, latch addr/wr/size/wdata, load wait_cnt=WAIT_STATES and stall_cnt=0, then go to ACCESS.
- ACCESS:
  - If stall_in=1: stall_cnt++, and wait_cnt holds.
  - If stall_cnt reaches TIMEOUT_CYCLES: set bus_timeout=1, bus_error=1, code=4, bus_ready=1 for one cycle, then go to ERR_HOLD.
  - Else if wait_cnt=0: evaluate the access and go to RESPOND. Else wait_cnt--.
- Latency: with stall_in=0, bus_ready is high exactly WAIT_STATES+2 cycles after the first edge that samples bus_req=1.
- Fault priority:
  - code 1: addr outside [BASE_ADDR, BASE_ADDR+DEPTH-1].
  - code 2: size != 2'b10.
  - code 3: write to [WP_BASE, WP_LIMIT].
  - code 0: none.
- Faulted access: no memory write; bus_rdata=0; bus_ready=1 with bus_error=1; go to ERR_HOLD.
- Good access:
  - Write stores wdata at index (addr-BASE_ADDR)[log2(DEPTH)-1:0].
  - Read drives the array word on bus_rdata.
  - bus_ready=1 for one cycle (RESPOND), then IDLE.
  - rd_count or wr_count increments, saturating at 0xFFFF.
- Back-to-back: bus_req sampled in the IDLE cycle that follows RESPOND starts a new transaction. No transaction is accepted during RESPOND.
- ERR_HOLD:
  - bus_req is ignored and no ready is issued.
  - bus_error_clear=1 clears error, code and timeout on the next edge, then IDLE.
  - err_count increments once per fault, on entry.
- bus_error_clear outside ERR_HOLD: ignored. If a fault is set in the same cycle as a clear, the set wins.
- bus_rdata returns to 0 when bus_ready deasserts.
- Reset mid-transaction aborts it: no memory write, no ready.

Decomposition:
- Shared constants (vtx1_state_constants / vtx1_interfaces):
  - target state encodings;
  - error codes 0–4 (VTX1_TGT_ERR_NONE/RANGE/SIZE/WPROT/TIMEOUT);
  - size encodings (VTX1_SIZE_WORD=2'b10).
- One sub-module: vtx1_sram_array. Parameters DEPTH and WORD_WIDTH; ports: one write port, one asynchronous-read port. It keeps the storage separate from the FSM.

Test Plan:
- Write 0x5A5 to 0x1004, then read 0x1004, WAIT_STATES=2 -> each ready pulses 4 cycles after req; rdata=0x5A5, error=0; wr_count=1, rd_count=1.
- Read 0x0FFF -> ready with error=1, code=1, rdata=0; req ignored until error_clear; then error=0, code=0, state IDLE; err_count=1.
- Write 0x10F8 with size=2'b10 -> code 3, and a later read of 0x10F8 returns its prior value. Read 0x1000 with size=2'b01 -> code 2.
- Hold stall_in=1 for 20 cycles during a read -> timeout=1, error=1, code=4 after 16 stall cycles, with one ready pulse.
- Back-to-back: 8 sequential read/write pairs (0x1000–0x1007 copied to 0x1010–0x1017), req held between pairs -> no missed or duplicated ready; destination matches source.
- Assert rst_n=0 during ACCESS of a write to 0x1020 -> all outputs 0 immediately; a later read of 0x1020 returns the pre-write value.

Source files
------------

// File: rtl/vtx1_bus_target_mem_pkg.sv
// Shared constants for the VTX1 bus target memory: FSM encodings, error codes
// and access-size encodings used by the target and its bench.
package vtx1_bus_target_mem_pkg;

  localparam int VTX1_ADDR_WIDTH = 16;
  localparam int VTX1_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    TGT_IDLE     = 2'd0,
    TGT_ACCESS   = 2'd1,
    TGT_RESPOND  = 2'd2,
    TGT_ERR_HOLD = 2'd3
  } tgt_state_t;

  localparam logic [3:0] VTX1_TGT_ERR_NONE    = 4'd0;
  localparam logic [3:0] VTX1_TGT_ERR_RANGE   = 4'd1;
  localparam logic [3:0] VTX1_TGT_ERR_SIZE    = 4'd2;
  localparam logic [3:0] VTX1_TGT_ERR_WPROT   = 4'd3;
  localparam logic [3:0] VTX1_TGT_ERR_TIMEOUT = 4'd4;

  localparam logic [1:0] VTX1_SIZE_BYTE = 2'b00;
  localparam logic [1:0] VTX1_SIZE_HALF = 2'b01;
  localparam logic [1:0] VTX1_SIZE_WORD = 2'b10;

endpackage

// File: rtl/vtx1_bus_target_mem_if.sv
// VTX1 master-side request/response bus as seen by a memory-mapped target.
interface vtx1_bus_target_mem_if
  import vtx1_bus_target_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = VTX1_ADDR_WIDTH,
  parameter int WORD_WIDTH = VTX1_WORD_WIDTH
);

  logic                  bus_req;
  logic                  bus_wr;
  logic [1:0]            bus_size;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [WORD_WIDTH-1:0] bus_wdata;
  logic [WORD_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;
  logic                  bus_error;
  logic [3:0]            bus_error_code;
  logic                  bus_timeout;
  logic                  bus_error_clear;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_error_clear,
    input  bus_rdata, bus_ready, bus_error, bus_error_code, bus_timeout
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_error_clear,
    output bus_rdata, bus_ready, bus_error, bus_error_code, bus_timeout
  );

endinterface

// File: rtl/vtx1_sram_array.sv
// Word storage behind the bus target: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module vtx1_sram_array #(
  parameter int DEPTH      = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_WIDTH-1:0]    rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vtx1_bus_target_mem.sv
// Word-addressed VTX1 bus target backed by a local array, with programmable
// wait states, stall timeout and sticky range/size/write-protect faults.
module vtx1_bus_target_mem
  import vtx1_bus_target_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = VTX1_ADDR_WIDTH,
  parameter int                    WORD_WIDTH     = VTX1_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'('h1000),
  parameter int                    DEPTH          = 256,
  parameter int                    WAIT_STATES    = 2,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [ADDR_WIDTH-1:0] WP_BASE        = ADDR_WIDTH'('h10F0),
  parameter logic [ADDR_WIDTH-1:0] WP_LIMIT       = ADDR_WIDTH'('h10FF)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vtx1_bus_target_mem_if.slave        bus,
  input  logic                        stall_in,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count,
  output logic [15:0]                 err_count
);

  localparam int                  IDX_W     = $clog2(DEPTH);
  localparam int                  STALL_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam bit                  WP_EN     = (WP_LIMIT >= WP_BASE);

  // Range beats size beats write-protect.
  function automatic logic [3:0] classify(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [1:0]            size,
                                          input logic                  wr);
    logic in_range;
    logic in_wp;
    in_range = (addr >= BASE_ADDR) && ({1'b0, addr} <= LAST_ADDR);
    in_wp    = WP_EN && (addr >= WP_BASE) && (addr <= WP_LIMIT);
    if (!in_range) begin
      return VTX1_TGT_ERR_RANGE;
    end else if (size != VTX1_SIZE_WORD) begin
      return VTX1_TGT_ERR_SIZE;
    end else if (wr && in_wp) begin
      return VTX1_TGT_ERR_WPROT;
    end
    return VTX1_TGT_ERR_NONE;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  tgt_state_t             state;
  tgt_state_t             state_nxt;
  logic [3:0]             wait_cnt;
  logic [STALL_W-1:0]     stall_cnt;
  logic [STALL_W-1:0]     stall_inc;
  logic                   stall_hit;

  logic                   wr_p0;
  logic [1:0]             size_p0;
  logic [ADDR_WIDTH-1:0]  addr_p0;
  logic [WORD_WIDTH-1:0]  wdata_p0;

  logic [3:0]             fault_code;
  logic                   fault;
  logic [IDX_W-1:0]       mem_idx;
  logic                   mem_we;
  logic [WORD_WIDTH-1:0]  mem_rdata;

  assign stall_inc  = stall_cnt + STALL_W'(1);
  assign stall_hit  = stall_in && (stall_inc == STALL_W'(TIMEOUT_CYCLES));
  assign fault_code = classify(addr_p0, size_p0, wr_p0);
  assign fault      = (fault_code != VTX1_TGT_ERR_NONE);
  assign mem_idx    = IDX_W'(addr_p0 - BASE_ADDR);
  // Writing only in RESPOND means a reset during ACCESS can never commit data.
  assign mem_we     = (state == TGT_RESPOND) && !fault && wr_p0;

  vtx1_sram_array #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_idx),
    .wdata (wdata_p0),
    .raddr (mem_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TGT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TGT_IDLE: begin
        if (bus.bus_req) begin
          state_nxt = TGT_ACCESS;
        end
      end
      TGT_ACCESS: begin
        if (stall_in) begin
          if (stall_hit) begin
            state_nxt = TGT_ERR_HOLD;
          end
        end else if (wait_cnt == 4'd0) begin
          state_nxt = TGT_RESPOND;
        end
      end
      TGT_RESPOND: begin
        state_nxt = fault ? TGT_ERR_HOLD : TGT_IDLE;
      end
      TGT_ERR_HOLD: begin
        if (bus.bus_error_clear) begin
          state_nxt = TGT_IDLE;
        end
      end
      default: state_nxt = TGT_IDLE;
    endcase
  end

  // Request capture stage: held by the master until ready, so no reset needed.
  always_ff @(posedge clk) begin
    if ((state == TGT_IDLE) && bus.bus_req) begin
      wr_p0    <= bus.bus_wr;
      size_p0  <= bus.bus_size;
      addr_p0  <= bus.bus_addr;
      wdata_p0 <= bus.bus_wdata;
    end
  end

  // Response stage: ready and rdata default low so each completion is one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt           <= 4'd0;
      stall_cnt          <= '0;
      bus.bus_ready      <= 1'b0;
      bus.bus_rdata      <= '0;
      bus.bus_error      <= 1'b0;
      bus.bus_error_code <= VTX1_TGT_ERR_NONE;
      bus.bus_timeout    <= 1'b0;
      rd_count           <= 16'd0;
      wr_count           <= 16'd0;
      err_count          <= 16'd0;
    end else begin
      bus.bus_ready <= 1'b0;
      bus.bus_rdata <= '0;
      case (state)
        TGT_IDLE: begin
          if (bus.bus_req) begin
            wait_cnt  <= 4'(WAIT_STATES);
            stall_cnt <= '0;
          end
        end
        TGT_ACCESS: begin
          if (stall_in) begin
            stall_cnt <= stall_inc;
            if (stall_hit) begin
              bus.bus_ready      <= 1'b1;
              bus.bus_error      <= 1'b1;
              bus.bus_error_code <= VTX1_TGT_ERR_TIMEOUT;
              bus.bus_timeout    <= 1'b1;
              err_count          <= sat_inc(err_count);
            end
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        TGT_RESPOND: begin
          bus.bus_ready <= 1'b1;
          if (fault) begin
            bus.bus_error      <= 1'b1;
            bus.bus_error_code <= fault_code;
            err_count          <= sat_inc(err_count);
          end else if (wr_p0) begin
            wr_count <= sat_inc(wr_count);
          end else begin
            rd_count      <= sat_inc(rd_count);
            bus.bus_rdata <= mem_rdata;
          end
        end
        TGT_ERR_HOLD: begin
          if (bus.bus_error_clear) begin
            bus.bus_error      <= 1'b0;
            bus.bus_error_code <= VTX1_TGT_ERR_NONE;
            bus.bus_timeout    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vtx1_bus_target_mem.sv
// Bench for vtx1_bus_target_mem: table of single transactions plus sequences
// for write-protect, stall timeout, back-to-back copies and mid-access reset.
module tb_vtx1_bus_target_mem;
  import vtx1_bus_target_mem_pkg::*;

  localparam int WAIT_STATES    = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int LAT            = WAIT_STATES + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  vtx1_bus_target_mem_if #(.ADDR_WIDTH(16), .WORD_WIDTH(32)) bus ();

  vtx1_bus_target_mem #(
    .ADDR_WIDTH     (16),
    .WORD_WIDTH     (32),
    .BASE_ADDR      (16'h1000),
    .DEPTH          (256),
    .WAIT_STATES    (WAIT_STATES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WP_BASE        (16'h10F0),
    .WP_LIMIT       (16'h10FF)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_in  (stall_in),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_code;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  code;
    logic        to;
    int          lat;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];
  int   checks = 0;
  int   fails  = 0;
  int   m_rd   = 0;
  int   m_wr   = 0;
  int   m_err  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rd_count"},  32'(rd_count),  32'(m_rd));
    chk({tag, "_wr_count"},  32'(wr_count),  32'(m_wr));
    chk({tag, "_err_count"}, 32'(err_count), 32'(m_err));
  endtask

  // Drive one request, then pop the expectation when ready appears.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit chk_rd,
                         input logic [3:0] exp_code, input logic exp_to, input int exp_lat,
                         input bit hold, output logic [31:0] got);
    exp_t e;
    exp_t g;
    int   lat;
    bit   seen;
    e.rdata  = ((exp_code == VTX1_TGT_ERR_NONE) && !wr) ? exp_rdata : 32'h0;
    e.err    = (exp_code != VTX1_TGT_ERR_NONE);
    e.code   = exp_code;
    e.to     = exp_to;
    e.lat    = exp_lat;
    e.chk_rd = chk_rd || wr || (exp_code != VTX1_TGT_ERR_NONE);
    sb.push_back(e);
    if (exp_code != VTX1_TGT_ERR_NONE) m_err++;
    else if (wr) m_wr++;
    else m_rd++;
    bus.bus_req   = 1'b1;
    bus.bus_wr    = wr;
    bus.bus_size  = size;
    bus.bus_addr  = addr;
    bus.bus_wdata = wdata;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      if (bus.bus_ready) seen = 1'b1;
      else lat++;
    end
    got = bus.bus_rdata;
    g = sb.pop_front();
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL ready_wait actual=no_ready required=ready addr=0x%0h", addr);
    end else begin
      chk("latency", 32'(lat), 32'(g.lat));
      if (g.chk_rd) chk("rdata", bus.bus_rdata, g.rdata);
      chk("error",   32'(bus.bus_error),      32'(g.err));
      chk("code",    32'(bus.bus_error_code), 32'(g.code));
      chk("timeout", 32'(bus.bus_timeout),    32'(g.to));
    end
    if (!hold) bus.bus_req = 1'b0;
  endtask

  // Called with req still high: ERR_HOLD must ignore it, then clear.
  task automatic clear_err(input logic [3:0] exp_code, input logic exp_to);
    int pulses;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.bus_ready) pulses++;
    end
    chk("hold_no_ready", 32'(pulses), 32'd0);
    chk("hold_error",    32'(bus.bus_error),      32'd1);
    chk("hold_code",     32'(bus.bus_error_code), 32'(exp_code));
    chk("hold_timeout",  32'(bus.bus_timeout),    32'(exp_to));
    bus.bus_req         = 1'b0;
    bus.bus_error_clear = 1'b1;
    @(negedge clk);
    bus.bus_error_clear = 1'b0;
    chk("clr_error",   32'(bus.bus_error),      32'd0);
    chk("clr_code",    32'(bus.bus_error_code), 32'd0);
    chk("clr_timeout", 32'(bus.bus_timeout),    32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"},   32'(bus.bus_ready),      32'd0);
    chk({tag, "_rdata"},   bus.bus_rdata,           32'd0);
    chk({tag, "_error"},   32'(bus.bus_error),      32'd0);
    chk({tag, "_code"},    32'(bus.bus_error_code), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.bus_timeout),    32'd0);
    chk({tag, "_rd_cnt"},  32'(rd_count),           32'd0);
    chk({tag, "_wr_cnt"},  32'(wr_count),           32'd0);
    chk({tag, "_err_cnt"}, 32'(err_count),          32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    logic [31:0] copy;

    vt[0]  = '{1'b1, VTX1_SIZE_WORD, 16'h1004, 32'h0000_05A5, 32'h0,         VTX1_TGT_ERR_NONE};
    vt[1]  = '{1'b0, VTX1_SIZE_WORD, 16'h1004, 32'h0,         32'h0000_05A5, VTX1_TGT_ERR_NONE};
    vt[2]  = '{1'b0, VTX1_SIZE_WORD, 16'h0FFF, 32'h0,         32'h0,         VTX1_TGT_ERR_RANGE};
    vt[3]  = '{1'b1, VTX1_SIZE_WORD, 16'h1000, 32'hA0A0_0001, 32'h0,         VTX1_TGT_ERR_NONE};
    vt[4]  = '{1'b0, VTX1_SIZE_WORD, 16'h1000, 32'h0,         32'hA0A0_0001, VTX1_TGT_ERR_NONE};
    vt[5]  = '{1'b0, VTX1_SIZE_HALF, 16'h1000, 32'h0,         32'h0,         VTX1_TGT_ERR_SIZE};
    vt[6]  = '{1'b1, VTX1_SIZE_WORD, 16'h10EF, 32'h0000_BEEF, 32'h0,         VTX1_TGT_ERR_NONE};
    vt[7]  = '{1'b0, VTX1_SIZE_WORD, 16'h10EF, 32'h0,         32'h0000_BEEF, VTX1_TGT_ERR_NONE};
    vt[8]  = '{1'b1, VTX1_SIZE_HALF, 16'h10F0, 32'h1111_1111, 32'h0,         VTX1_TGT_ERR_SIZE};
    vt[9]  = '{1'b0, VTX1_SIZE_WORD, 16'h1100, 32'h0,         32'h0,         VTX1_TGT_ERR_RANGE};
    vt[10] = '{1'b1, VTX1_SIZE_BYTE, 16'h0FFF, 32'h2222_2222, 32'h0,         VTX1_TGT_ERR_RANGE};
    vt[11] = '{1'b1, VTX1_SIZE_WORD, 16'h10FF, 32'h3333_3333, 32'h0,         VTX1_TGT_ERR_WPROT};

    rst_n               = 1'b0;
    stall_in            = 1'b0;
    bus.bus_req         = 1'b0;
    bus.bus_wr          = 1'b0;
    bus.bus_size        = VTX1_SIZE_WORD;
    bus.bus_addr        = 16'h0;
    bus.bus_wdata       = 32'h0;
    bus.bus_error_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_txn(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, 1'b1,
              vt[i].exp_code, 1'b0, LAT, vt[i].exp_code != VTX1_TGT_ERR_NONE, got);
      if (vt[i].exp_code != VTX1_TGT_ERR_NONE) clear_err(vt[i].exp_code, 1'b0);
      @(negedge clk);
      chk("idle_ready_low", 32'(bus.bus_ready), 32'd0);
    end
    chk_counts("table");

    // Protected write must leave the word unchanged.
    run_txn(1'b0, VTX1_SIZE_WORD, 16'h10F8, 32'h0, 32'h0, 1'b0, VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b0, prior);
    run_txn(1'b1, VTX1_SIZE_WORD, 16'h10F8, ~prior, 32'h0, 1'b1, VTX1_TGT_ERR_WPROT, 1'b0, LAT, 1'b1, got);
    clear_err(VTX1_TGT_ERR_WPROT, 1'b0);
    run_txn(1'b0, VTX1_SIZE_WORD, 16'h10F8, 32'h0, prior, 1'b1, VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b0, got);

    // Stall through the whole access: timeout after TIMEOUT_CYCLES stalls.
    stall_in = 1'b1;
    run_txn(1'b0, VTX1_SIZE_WORD, 16'h1004, 32'h0, 32'h0, 1'b1, VTX1_TGT_ERR_TIMEOUT, 1'b1,
            TIMEOUT_CYCLES, 1'b1, got);
    clear_err(VTX1_TGT_ERR_TIMEOUT, 1'b1);
    stall_in = 1'b0;
    chk_counts("timeout");

    // Back-to-back with req held: fill source, copy pairs, read destination.
    for (int i = 0; i < 8; i++)
      run_txn(1'b1, VTX1_SIZE_WORD, 16'h1000 + 16'(i), 32'hC0DE_0000 + 32'(i), 32'h0, 1'b1,
              VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b1, got);
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, VTX1_SIZE_WORD, 16'h1000 + 16'(i), 32'h0, 32'hC0DE_0000 + 32'(i), 1'b1,
              VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b1, copy);
      run_txn(1'b1, VTX1_SIZE_WORD, 16'h1010 + 16'(i), copy, 32'h0, 1'b1,
              VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b1, got);
    end
    for (int i = 0; i < 8; i++)
      run_txn(1'b0, VTX1_SIZE_WORD, 16'h1010 + 16'(i), 32'h0, 32'hC0DE_0000 + 32'(i), 1'b1,
              VTX1_TGT_ERR_NONE, 1'b0, LAT, i != 7, got);
    chk_counts("b2b");

    // Reset during ACCESS of a write aborts it.
    run_txn(1'b1, VTX1_SIZE_WORD, 16'h1020, 32'h0000_1234, 32'h0, 1'b1,
            VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b0, got);
    bus.bus_req   = 1'b1;
    bus.bus_wr    = 1'b1;
    bus.bus_size  = VTX1_SIZE_WORD;
    bus.bus_addr  = 16'h1020;
    bus.bus_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    bus.bus_req = 1'b0;
    m_rd  = 0;
    m_wr  = 0;
    m_err = 0;
    repeat (6) @(negedge clk);
    chk("midrst_no_ready", 32'(bus.bus_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, VTX1_SIZE_WORD, 16'h1020, 32'h0, 32'h0000_1234, 1'b1,
            VTX1_TGT_ERR_NONE, 1'b0, LAT, 1'b0, got);
    chk_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
